// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_ctrl
// Description : Multicycle CPU control unit. Sequences each instruction
//               through IF/ID/EXE/MEM/WB states, drives the datapath strobes
//               and PC load controls, and counts retired instructions.
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  opcode,
    input  logic        zero,
    output logic        pcWre,
    output logic        irWre,
    output logic        regWre,
    output logic        mRD,
    output logic        mWR,
    output logic [1:0]  PCSrc,
    output logic [1:0]  RegDst,
    output logic [2:0]  ALUOp,
    output logic        ALUSrcB,
    output logic        ExtSel,
    output logic        DBDataSrc,
    output logic        WrRegDSrc,
    output logic [3:0]  state,
    output logic [31:0] instr_cnt
);

    // Opcode encodings
    localparam logic [5:0] c_OP_ADD  = 6'b000000;
    localparam logic [5:0] c_OP_SUB  = 6'b000001;
    localparam logic [5:0] c_OP_ADDI = 6'b000010;
    localparam logic [5:0] c_OP_AND  = 6'b010001;
    localparam logic [5:0] c_OP_ORI  = 6'b010010;
    localparam logic [5:0] c_OP_SLT  = 6'b100110;
    localparam logic [5:0] c_OP_SW   = 6'b110000;
    localparam logic [5:0] c_OP_LW   = 6'b110001;
    localparam logic [5:0] c_OP_BEQ  = 6'b110100;
    localparam logic [5:0] c_OP_BNE  = 6'b110101;
    localparam logic [5:0] c_OP_J    = 6'b111000;
    localparam logic [5:0] c_OP_JR   = 6'b111001;
    localparam logic [5:0] c_OP_JAL  = 6'b111010;
    localparam logic [5:0] c_OP_HALT = 6'b111111;

    // ALU operation codes
    localparam logic [2:0] c_ALU_ADD = 3'b000;
    localparam logic [2:0] c_ALU_SUB = 3'b001;
    localparam logic [2:0] c_ALU_OR  = 3'b010;
    localparam logic [2:0] c_ALU_AND = 3'b011;
    localparam logic [2:0] c_ALU_SLT = 3'b100;

    // PC source selects
    localparam logic [1:0] c_PC_INC  = 2'b00;
    localparam logic [1:0] c_PC_BR   = 2'b01;
    localparam logic [1:0] c_PC_RS   = 2'b10;
    localparam logic [1:0] c_PC_JMP  = 2'b11;

    // Register destination selects
    localparam logic [1:0] c_RD_R31  = 2'b00;
    localparam logic [1:0] c_RD_RT   = 2'b01;
    localparam logic [1:0] c_RD_RD   = 2'b10;

    typedef enum logic [3:0] {
        S_IF     = 4'b0000,
        S_ID     = 4'b0001,
        S_EXE_LS = 4'b0010,
        S_MEM    = 4'b0011,
        S_WB_LD  = 4'b0100,
        S_EXE_BR = 4'b0101,
        S_EXE_AL = 4'b0110,
        S_WB_AL  = 4'b0111,
        S_HALT   = 4'b1000
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [31:0] r_instr_cnt;

    // Opcode class decode
    logic w_is_add, w_is_sub, w_is_addi, w_is_and, w_is_ori, w_is_slt;
    logic w_is_sw, w_is_lw, w_is_beq, w_is_bne;
    logic w_is_j, w_is_jr, w_is_jal, w_is_halt;
    logic w_is_alu, w_is_branch, w_is_ldst, w_is_nop;

    assign w_is_add    = (opcode == c_OP_ADD);
    assign w_is_sub    = (opcode == c_OP_SUB);
    assign w_is_addi   = (opcode == c_OP_ADDI);
    assign w_is_and    = (opcode == c_OP_AND);
    assign w_is_ori    = (opcode == c_OP_ORI);
    assign w_is_slt    = (opcode == c_OP_SLT);
    assign w_is_sw     = (opcode == c_OP_SW);
    assign w_is_lw     = (opcode == c_OP_LW);
    assign w_is_beq    = (opcode == c_OP_BEQ);
    assign w_is_bne    = (opcode == c_OP_BNE);
    assign w_is_j      = (opcode == c_OP_J);
    assign w_is_jr     = (opcode == c_OP_JR);
    assign w_is_jal    = (opcode == c_OP_JAL);
    assign w_is_halt   = (opcode == c_OP_HALT);

    assign w_is_alu    = w_is_add | w_is_sub | w_is_addi | w_is_and | w_is_ori | w_is_slt;
    assign w_is_branch = w_is_beq | w_is_bne;
    assign w_is_ldst   = w_is_lw | w_is_sw;
    // Anything unrecognised retires as a two-cycle nop
    assign w_is_nop    = ~(w_is_alu | w_is_branch | w_is_ldst |
                           w_is_j | w_is_jr | w_is_jal | w_is_halt);

    // ALU operation implied by the current ALU-class opcode
    logic [2:0] w_alu_fn;
    always_comb begin
        w_alu_fn = c_ALU_ADD;
        if (w_is_sub)      w_alu_fn = c_ALU_SUB;
        else if (w_is_and) w_alu_fn = c_ALU_AND;
        else if (w_is_ori) w_alu_fn = c_ALU_OR;
        else if (w_is_slt) w_alu_fn = c_ALU_SLT;
    end

    // Ungated datapath controls, before reset masking
    logic       w_pcwre, w_irwre, w_regwre, w_mrd, w_mwr;
    logic [1:0] w_pcsrc, w_regdst;
    logic [2:0] w_aluop;
    logic       w_alusrcb, w_extsel, w_dbdatasrc, w_wrregdsrc;
    logic       w_br_taken;

    assign w_br_taken = (w_is_beq & zero) | (w_is_bne & ~zero);

    // State register: reset parks the sequencer in IF
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IF;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state selection and per-state control decode
    always_comb begin
        w_next_state = S_IF;
        w_pcwre      = 1'b0;
        w_irwre      = 1'b0;
        w_regwre     = 1'b0;
        w_mrd        = 1'b0;
        w_mwr        = 1'b0;
        w_pcsrc      = c_PC_INC;
        w_regdst     = c_RD_R31;
        w_aluop      = c_ALU_ADD;
        w_alusrcb    = 1'b0;
        w_extsel     = 1'b0;
        w_dbdatasrc  = 1'b0;
        w_wrregdsrc  = 1'b0;

        case (r_state)
            S_IF: begin
                w_irwre      = 1'b1;
                w_next_state = S_ID;
            end

            S_ID: begin
                if (w_is_alu) begin
                    w_next_state = S_EXE_AL;
                end else if (w_is_branch) begin
                    w_next_state = S_EXE_BR;
                end else if (w_is_ldst) begin
                    w_next_state = S_EXE_LS;
                end else if (w_is_halt) begin
                    w_next_state = S_HALT;
                end else begin
                    // Jumps and nops retire here
                    w_next_state = S_IF;
                    w_pcwre      = 1'b1;
                    if (w_is_j) begin
                        w_pcsrc = c_PC_JMP;
                    end else if (w_is_jr) begin
                        w_pcsrc = c_PC_RS;
                    end else if (w_is_jal) begin
                        w_pcsrc     = c_PC_JMP;
                        w_regwre    = 1'b1;
                        w_regdst    = c_RD_R31;
                        w_wrregdsrc = 1'b0;
                    end else if (w_is_nop) begin
                        w_pcsrc = c_PC_INC;
                    end
                end
            end

            S_EXE_AL, S_WB_AL: begin
                w_aluop   = w_alu_fn;
                w_alusrcb = w_is_addi | w_is_ori;
                w_extsel  = w_is_addi;
                if (r_state == S_WB_AL) begin
                    w_next_state = S_IF;
                    w_regwre     = 1'b1;
                    w_wrregdsrc  = 1'b1;
                    w_dbdatasrc  = 1'b0;
                    w_regdst     = (w_is_addi | w_is_ori) ? c_RD_RT : c_RD_RD;
                    w_pcwre      = 1'b1;
                    w_pcsrc      = c_PC_INC;
                end else begin
                    w_next_state = S_WB_AL;
                end
            end

            S_EXE_BR: begin
                w_next_state = S_IF;
                w_aluop      = c_ALU_SUB;
                w_extsel     = 1'b1;
                w_pcwre      = 1'b1;
                w_pcsrc      = w_br_taken ? c_PC_BR : c_PC_INC;
            end

            S_EXE_LS: begin
                w_next_state = S_MEM;
                w_aluop      = c_ALU_ADD;
                w_alusrcb    = 1'b1;
                w_extsel     = 1'b1;
            end

            S_MEM: begin
                w_aluop   = c_ALU_ADD;
                w_alusrcb = 1'b1;
                w_extsel  = 1'b1;
                if (w_is_lw) begin
                    w_next_state = S_WB_LD;
                    w_mrd        = 1'b1;
                end else begin
                    // Store retires once the write is issued
                    w_next_state = S_IF;
                    w_mwr        = 1'b1;
                    w_pcwre      = 1'b1;
                    w_pcsrc      = c_PC_INC;
                end
            end

            S_WB_LD: begin
                w_next_state = S_IF;
                w_regwre     = 1'b1;
                w_dbdatasrc  = 1'b1;
                w_wrregdsrc  = 1'b1;
                w_regdst     = c_RD_RT;
                w_pcwre      = 1'b1;
                w_pcsrc      = c_PC_INC;
            end

            S_HALT: begin
                w_next_state = S_HALT;
            end

            default: begin
                w_next_state = S_IF;
            end
        endcase
    end

    // Retired-instruction counter, advancing on every PC load
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_instr_cnt <= 32'd0;
        end else if (w_pcwre) begin
            r_instr_cnt <= r_instr_cnt + 32'd1;
        end
    end

    // While reset is low every control output is held at zero,
    // including irWre which would otherwise be high in IF.
    assign pcWre     = reset & w_pcwre;
    assign irWre     = reset & w_irwre;
    assign regWre    = reset & w_regwre;
    assign mRD       = reset & w_mrd;
    assign mWR       = reset & w_mwr;
    assign PCSrc     = reset ? w_pcsrc  : 2'b00;
    assign RegDst    = reset ? w_regdst : 2'b00;
    assign ALUOp     = reset ? w_aluop  : 3'b000;
    assign ALUSrcB   = reset & w_alusrcb;
    assign ExtSel    = reset & w_extsel;
    assign DBDataSrc = reset & w_dbdatasrc;
    assign WrRegDSrc = reset & w_wrregdsrc;
    assign state     = r_state;
    assign instr_cnt = r_instr_cnt;

endmodule
`default_nettype wire

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multicycle control unit that sequences every instruction through IF/ID/EXE/MEM/WB states and drives the datapath strobes. It sits directly upstream of the program-counter register: its `pcWre` and `PCSrc` outputs decide when, and from which source, the PC loads its next value. It also counts retired instructions for debug.

## Interface

- Parameters: none.
- clk  input  1  system clock, rising-edge active.
- reset  input  1  asynchronous, active-low (0 = reset).
- opcode  input  6  instruction opcode from the IR; stable from ID onward.
- zero  input  1  ALU zero flag; sampled in EXE_BR.
- pcWre  output  1  PC write enable; one cycle per instruction.
- irWre  output  1  instruction register write enable.
- regWre  output  1  register file write enable.
- mRD  output  1  data memory read.
- mWR  output  1  data memory write.
- PCSrc  output  2  00 PC+4, 01 PC+4+(sext(imm)<<2), 10 rs, 11 jump target.
- RegDst  output  2  00 $31, 01 rt, 10 rd.
- ALUOp  output  3  000 add, 001 sub, 010 or, 011 and, 100 slt.
- ALUSrcB  output  1  0 rt, 1 extended immediate.
- ExtSel  output  1  0 zero-extend, 1 sign-extend.
- DBDataSrc  output  1  0 ALU result, 1 memory data.
- WrRegDSrc  output  1  0 PC+4, 1 DB.
- state  output  4  current state code, for debug.
- instr_cnt  output  32  retired-instruction count.

## Operation

- Opcodes: add 000000, sub 000001, addi 000010, and 010001, ori 010010, slt 100110, sw 110000, lw 110001, beq 110100, bne 110101, j 111000, jr 111001, jal 111010, halt 111111. Any other opcode is a nop.
- States and codes: IF 0000, ID 0001, EXE_AL 0110, EXE_BR 0101, EXE_LS 0010, MEM 0011, WB_AL 0111, WB_LD 0100, HALT 1000.
- Transitions:
  - IF→ID always.
  - From ID:
    - add/sub/addi/and/ori/slt → EXE_AL.
    - beq/bne → EXE_BR.
    - lw/sw → EXE_LS.
    - j/jr/jal/nop → IF.
    - halt → HALT.
  - EXE_AL→WB_AL→IF.
  - EXE_BR→IF.
  - EXE_LS→MEM.
  - MEM→WB_LD (lw) or MEM→IF (sw).
  - WB_LD→IF.
  - HALT→HALT until reset.
- Outputs are combinational from state, opcode and zero. Any output not listed for a state is 0.
  - IF: irWre=1.
  - ID:
    - j: pcWre=1, PCSrc=11.
    - jr: pcWre=1, PCSrc=10.
    - jal: pcWre=1, PCSrc=11, regWre=1, RegDst=00, WrRegDSrc=0.
    - nop: pcWre=1, PCSrc=00.
  - EXE_AL / WB_AL:
    - ALUOp per opcode; addi uses add.
    - ALUSrcB=1 and ExtSel=1 for addi; ALUSrcB=1 and ExtSel=0 for ori.
    - In WB_AL additionally: regWre=1, WrRegDSrc=1, DBDataSrc=0, RegDst=01 for addi/ori and 10 otherwise, pcWre=1, PCSrc=00.
  - EXE_BR: ALUOp=001, ExtSel=1, pcWre=1.
    - PCSrc=01 if (beq and zero) or (bne and !zero); otherwise 00.
  - EXE_LS: ALUOp=000, ALUSrcB=1, ExtSel=1.
  - MEM: ALUOp=000, ALUSrcB=1, ExtSel=1.
    - lw: mRD=1.
    - sw: mWR=1, pcWre=1, PCSrc=00.
  - WB_LD: regWre=1, DBDataSrc=1, WrRegDSrc=1, RegDst=01, pcWre=1, PCSrc=00.
  - HALT: all strobes 0.
- instr_cnt increments by 1 on each rising edge where pcWre=1. It wraps from 0xFFFFFFFF to 0.

## Timing

- State register and instr_cnt update on the rising edge of clk.
- reset=0 asynchronously forces state=IF and instr_cnt=0, and forces every strobe to 0 (pcWre, irWre, regWre, mRD, mWR). This applies at any point, including mid-instruction or in HALT.
- While reset=0, the select outputs take their IF values, i.e. 0.
- After reset rises, the first edge-bearing cycle is IF with irWre=1.
- Cycle counts per instruction: j/jr/jal/nop 2, beq/bne 3, R-type/addi/ori 4, sw 4, lw 5.
- pcWre is high for exactly one cycle per instruction, in that instruction's final state. It is never high in IF.
- zero is used only during EXE_BR. Glitches on zero in other states have no effect.
- An opcode change after ID is not permitted. Its effect on outputs is undefined.

## Test plan

- Reset held low for 3 cycles, then released → state=0000, all strobes 0, instr_cnt=0; the next cycle is IF with irWre=1.
- add (000000) → states 0000,0001,0110,0111,0000; in WB_AL regWre=1, RegDst=10, pcWre=1; instr_cnt=1.
- lw (110001) then sw (110000) → lw asserts mRD in MEM and regWre, DBDataSrc=1 in WB_LD; sw asserts mWR and pcWre in MEM and returns to IF; instr_cnt=2.
- beq with zero=1 → PCSrc=01 in EXE_BR. Same with zero=0 → PCSrc=00. bne with zero=0 → PCSrc=01. Each takes 3 cycles.
- jal (111010) → in ID: pcWre=1, PCSrc=11, regWre=1, RegDst=00, WrRegDSrc=0. 2-cycle instruction.
- halt (111111) → enters HALT and stays there 10 cycles with pcWre=0 and instr_cnt frozen. reset=0 asserted mid-cycle → state=0000 immediately, without waiting for a clock edge.
